bus_arbiter: RTL

Round-robin arbiter sharing the single serial data bus between up to `NUM_MASTERS` masters. It grants one master at a time, drives the shared `bus_util` framing line for the owner's transaction, and holds the bus through slave-busy periods. It forcibly reclaims the bus from a master that exceeds a cycle budget. It sits beside the slaves on the bus backplane and is the only driver of `bus_util`.

---
 rtl/bus_pkg.sv | 23 ++
 rtl/rr_picker.sv | 41 ++++
 rtl/bus_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : bus_pkg
//  Description : Serial bus constants and arbiter state encoding shared by
//                the arbiter and the slaves on the backplane.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    localparam int ADDRESS_WIDTH  = 15;
    localparam int DATA_WIDTH     = 8;
    localparam int SLAVE_ID_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ACTIVE     = 2'd1,
        WAIT_SLAVE = 2'd2,
        TURNAROUND = 2'd3
    } bus_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin winner search, starting one slot
//                after the previous owner and wrapping around.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ID_WIDTH    = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] eligible,
    input  logic [ID_WIDTH-1:0]    last_id,
    output logic                   found,
    output logic [ID_WIDTH-1:0]    win_id,
    output logic [NUM_MASTERS-1:0] win
);

    logic [ID_WIDTH-1:0] w_idx;

    always_comb begin
        found  = 1'b0;
        win_id = '0;
        win    = '0;
        w_idx  = '0;
        // The previous owner is visited last, so it only wins when alone.
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            w_idx = ID_WIDTH'((int'(last_id) + k) % NUM_MASTERS);
            if (!found && eligible[w_idx]) begin
                found      = 1'b1;
                win_id     = w_idx;
                win[w_idx] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Round-robin owner of the shared serial bus with slave-busy
//                hold-off, release gap and per-grant timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NUM_MASTERS-1:0]         req,
    input  logic                           slave_busy,
    output logic [NUM_MASTERS-1:0]         grant,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_id,
    output logic                           bus_util,
    output logic                           timeout_err
);

    localparam int               c_ID_W    = $clog2(NUM_MASTERS);
    localparam int               c_CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic             c_TO_EN   = (TIMEOUT_CYCLES > 0);

    bus_state_t             r_state;
    bus_state_t             w_next_state;
    logic [c_ID_W-1:0]      r_last_id;
    logic [NUM_MASTERS-1:0] r_owner_oh;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [NUM_MASTERS-1:0] r_mask;
    logic                   r_to_evt;

    logic [NUM_MASTERS-1:0] w_eligible;
    logic                   w_found;
    logic [c_ID_W-1:0]      w_win_id;
    logic [NUM_MASTERS-1:0] w_win;
    logic                   w_owner_req;
    logic                   w_revoke;
    logic                   w_release;
    logic [NUM_MASTERS-1:0] w_grant_d;
    logic [c_ID_W-1:0]      w_grant_id_d;
    logic                   w_bus_util_d;

    assign w_eligible  = req & ~r_mask;
    assign w_owner_req = |(req & r_owner_oh);
    assign w_revoke    = c_TO_EN && (r_state == ACTIVE) && w_owner_req && (r_cnt == c_TO_LAST);
    assign w_release   = (r_state == ACTIVE) && (!w_owner_req || w_revoke);

    rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .ID_WIDTH    (c_ID_W)
    ) u_picker (
        .eligible (w_eligible),
        .last_id  (r_last_id),
        .found    (w_found),
        .win_id   (w_win_id),
        .win      (w_win)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:       if (w_found) w_next_state = ACTIVE;
            ACTIVE:     if (w_release) w_next_state = slave_busy ? WAIT_SLAVE : TURNAROUND;
            WAIT_SLAVE: if (!slave_busy) w_next_state = TURNAROUND;
            TURNAROUND: w_next_state = IDLE;
            default:    w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_grant_d    = '0;
        w_grant_id_d = '0;
        w_bus_util_d = 1'b0;
        if (r_state == ACTIVE) begin
            w_grant_d    = r_owner_oh;
            w_grant_id_d = r_last_id;
            w_bus_util_d = 1'b1;
        end
    end

    // A revoked master stays masked until it lowers req for at least one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_last_id  <= c_ID_W'(NUM_MASTERS - 1);
            r_owner_oh <= '0;
            r_cnt      <= '0;
            r_mask     <= '0;
            r_to_evt   <= 1'b0;
        end else begin
            r_to_evt <= w_revoke;
            r_mask   <= (r_mask & req) | (w_revoke ? r_owner_oh : '0);
            if ((r_state == IDLE) && w_found) begin
                r_last_id  <= w_win_id;
                r_owner_oh <= w_win;
                r_cnt      <= '0;
            end else if ((r_state == ACTIVE) && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grant       <= '0;
            grant_id    <= '0;
            bus_util    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            grant       <= w_grant_d;
            grant_id    <= w_grant_id_d;
            bus_util    <= w_bus_util_d;
            timeout_err <= r_to_evt;
        end
    end

endmodule
`default_nettype wire
